fetch_unit: RTL and testbench

- Stage 1 of the 7-stage pipeline. Holds the PC and issues word fetches to instruction memory over a request/grant, in-order-response interface.
- Buffers returned instructions in a small queue and presents one instruction per cycle as `line` to the decode stage.
- Handles decode back-pressure (`stall`) and control-flow redirects from later stages, including discarding wrong-path responses still in flight.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- stage 1 of the 7-stage pipeline.
//
// Holds the fetch PC and issues word fetches to instruction memory over a
// request/grant interface whose responses return in request order. Returned
// words are buffered in a small queue and presented one per cycle to decode.
// Redirects from later stages flush the queue, restart fetch at the new PC
// and discard every response still in flight for the old path.
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned)
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response valid (in order, >= 1 cycle after grant)
//   imem_rdata      returned instruction word
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new PC, bits [1:0] ignored
//   stall           decode cannot accept line this cycle
//   line            instruction to decode (NOP_WORD when not valid)
//   line_pc         PC of line (0 when not valid)
//   line_valid      line holds a real instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] line,
    output logic [31:0] line_pc,
    output logic        line_valid
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   q_data [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] q_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic [CW:0]   in_use;
    logic [31:0]   target_pc;
    logic          grant;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic          unused_ok;

    // Queued plus in-flight words may never exceed the queue size, so every
    // response is guaranteed a free slot.
    assign in_use    = {1'b0, q_count} + {1'b0, outstanding};
    assign target_pc = {redirect_pc[31:2], 2'b00};
    assign unused_ok = ^redirect_pc[1:0];

    // reset_n term keeps the request low while reset is held.
    assign imem_req  = reset_n && !redirect_valid && (in_use < DEPTH_W);
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok = imem_rvalid && (outstanding != '0);
    assign push   = rsp_ok && (drop_cnt == '0) && !redirect_valid;

    assign line_valid = (q_count != '0) && !redirect_valid;
    assign pop        = line_valid && !stall;
    assign line       = line_valid ? q_data[rd_ptr] : NOP_WORD;
    assign line_pc    = line_valid ? q_pc[rd_ptr]   : 32'h0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q_count     <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old
            // path, including responses already being dropped.
            pc          <= target_pc;
            rsp_pc      <= target_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            q_count     <= '0;
            outstanding <= outstanding - CW'(rsp_ok);
            drop_cnt    <= outstanding - CW'(rsp_ok);
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + CW'(grant) - CW'(rsp_ok);
            if (rsp_ok && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            // The tracker only advances on kept responses so it always names
            // the PC of the next word that will enter the queue.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage carries no reset; occupancy is tracked by q_count.
    always_ff @(posedge clock) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clock) disable iff (!reset_n)
        !(imem_rvalid && (outstanding == '0)));

    a_counter_bounds: assert property (@(posedge clock) disable iff (!reset_n)
        (drop_cnt <= outstanding) && ({1'b0, outstanding} <= DEPTH_W));

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (q_count == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- randomized bench for fetch_unit.
//
// An instruction-memory model returns mem_word(addr) for every granted
// request, in order, after a random latency. A reference model tracks the
// expected fetch address, the words in flight (tagged with the redirect epoch
// they were requested in) and the list of lines decode should see.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] line;
    logic [31:0] line_pc;
    logic        line_valid;

    fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH),
        .NOP_WORD    (NOP)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .line           (line),
        .line_pc        (line_pc),
        .line_valid     (line_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } line_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } req_t;

    line_t       mq[$];
    req_t        fl[$];
    logic [31:0] exp_pc;
    int          epoch;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_1357;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 4) == 0)
            return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return $urandom & 32'h0000_3FFF;
    endfunction

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // advance the reference model, then step to just after the rising edge.
    task automatic step(input int p_redir, input int p_stall, input int p_gnt,
                        input int p_rv, input int max_lat,
                        input bit f_redir, input logic [31:0] f_pc);
        bit          do_redir;
        bit          exp_req;
        bit          exp_lv;
        bit          do_push;
        req_t        r;
        req_t        nr;
        line_t       nl;
        do_redir = f_redir || (int'($urandom_range(0, 99)) < p_redir);
        redirect_valid = do_redir;
        redirect_pc    = f_redir ? f_pc : rand_target();
        stall          = int'($urandom_range(0, 99)) < p_stall;
        imem_gnt       = int'($urandom_range(0, 99)) < p_gnt;
        imem_rvalid    = (fl.size() > 0) && (fl[0].ready <= cyc) &&
                         (int'($urandom_range(0, 99)) < p_rv);
        imem_rdata     = imem_rvalid ? mem_word(fl[0].addr) : $urandom;

        @(negedge clock);
        exp_req = !do_redir && ((mq.size() + fl.size()) < DEPTH);
        exp_lv  = (mq.size() > 0) && !do_redir;
        check_val("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) check_val("imem_addr", imem_addr, exp_pc);
        check_val("line_valid", {31'b0, line_valid}, {31'b0, exp_lv});
        check_val("line",    line,    exp_lv ? mq[0].word : NOP);
        check_val("line_pc", line_pc, exp_lv ? mq[0].pc   : 32'h0);

        do_push = 1'b0;
        if (imem_rvalid) begin
            r = fl.pop_front();
            if (r.epoch == epoch && !do_redir) begin
                do_push = 1'b1;
                nl.pc   = r.addr;
                nl.word = mem_word(r.addr);
            end
        end
        if (do_redir) begin
            mq.delete();
            epoch++;
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (exp_lv && !stall) void'(mq.pop_front());
            if (do_push) mq.push_back(nl);
            if (exp_req && imem_gnt) begin
                nr.addr  = exp_pc;
                nr.epoch = epoch;
                nr.ready = cyc + int'($urandom_range(1, max_lat));
                fl.push_back(nr);
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        epoch          = 0;
        exp_pc         = RESET_PC;
        reset_n        = 1'b0;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_imem_req",   {31'b0, imem_req},   32'h0);
        check_val("rst_line_valid", {31'b0, line_valid}, 32'h0);
        check_val("rst_line",       line,                NOP);
        check_val("rst_line_pc",    line_pc,             32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Streaming with full grant and single-cycle responses.
        repeat (20) step(0, 0, 100, 100, 1, 1'b0, 32'h0);
        // Decode stalled long enough to fill the queue, then released.
        repeat (12) step(0, 100, 100, 100, 1, 1'b0, 32'h0);
        repeat (10) step(0, 0, 100, 100, 1, 1'b0, 32'h0);
        // Long latency with words in flight, then a redirect.
        repeat (3)  step(0, 0, 100, 100, 3, 1'b0, 32'h0);
        step(0, 0, 100, 100, 3, 1'b1, 32'h0000_0100);
        repeat (12) step(0, 0, 100, 100, 3, 1'b0, 32'h0);
        // Redirect to an unaligned target while stalled with a full queue.
        repeat (10) step(0, 100, 100, 100, 1, 1'b0, 32'h0);
        step(0, 100, 100, 100, 1, 1'b1, 32'h0000_0203);
        repeat (10) step(0, 0, 100, 100, 1, 1'b0, 32'h0);
        // Back-to-back redirects.
        repeat (4) step(0, 0, 100, 100, 2, 1'b0, 32'h0);
        step(0, 0, 100, 100, 2, 1'b1, 32'h0000_0400);
        step(0, 0, 100, 100, 2, 1'b1, 32'h0000_0800);
        repeat (10) step(0, 0, 100, 100, 2, 1'b0, 32'h0);
        // Fully random traffic.
        repeat (3000) step(4, 30, 70, 70, 4, 1'b0, 32'h0);
        // Drain with no further disturbance.
        repeat (30) step(0, 0, 100, 100, 4, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
